// File: rtl/spi_shift_engine_p.sv
// SPI shift engine: serialises one frame of up to DATA_W bits onto mosi_o while
// capturing miso_i.  SCLK edges arrive as one-PCLK strobes from an external generator.
module spi_shift_engine_p #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              PCLK,
    input  logic              PRESET_n,
    input  logic              ss_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_tx_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic              lsbfe_i,
    input  logic              cpha_i,
    input  logic              lead_edge_i,
    input  logic              trail_edge_i,
    input  logic              miso_i,
    output logic              mosi_o,
    output logic [DATA_W-1:0] data_rx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              abort_o
);

    typedef enum logic {ST_IDLE, ST_XFER} state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic [CNT_W-1:0]    r_len;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W:0]      r_drv_cnt;
    logic                r_lsbfe;
    logic                r_cpha;

    logic                w_drive;
    logic                w_sample;
    logic                w_drv_ok;
    logic [CNT_W-1:0]    w_first_idx;
    logic [CNT_W-1:0]    w_tx_idx;
    logic [CNT_W-1:0]    w_rx_idx;
    logic [DATA_W-1:0]   w_rx_next;

    // r_drv_cnt counts bits already placed on mosi_o; one extra bit keeps it from wrapping.
    always_comb begin
        w_drive     = r_cpha ? lead_edge_i  : trail_edge_i;
        w_sample    = r_cpha ? trail_edge_i : lead_edge_i;
        w_drv_ok    = (r_drv_cnt <= {1'b0, r_len});
        w_first_idx = lsbfe_i ? '0 : len_i;
        w_tx_idx    = r_lsbfe ? r_drv_cnt[CNT_W-1:0] : r_len - r_drv_cnt[CNT_W-1:0];
        w_rx_idx    = r_lsbfe ? r_cnt : r_len - r_cnt;
        w_rx_next   = r_rx;
        w_rx_next[w_rx_idx] = miso_i;
    end

    assign busy_o = (r_state == ST_XFER);

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_state   <= ST_IDLE;
            r_tx      <= '0;
            r_rx      <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_drv_cnt <= '0;
            r_lsbfe   <= 1'b0;
            r_cpha    <= 1'b0;
            mosi_o    <= 1'b0;
            data_rx_o <= '0;
            done_o    <= 1'b0;
            abort_o   <= 1'b0;
        end else begin
            done_o  <= 1'b0;
            abort_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i && !ss_i) begin
                        r_state <= ST_XFER;
                        r_tx    <= data_tx_i;
                        r_len   <= len_i;
                        r_lsbfe <= lsbfe_i;
                        r_cpha  <= cpha_i;
                        r_cnt   <= '0;
                        r_rx    <= '0;
                        // cpha=0 puts the first bit out immediately; cpha=1 waits for a lead edge
                        if (!cpha_i) begin
                            mosi_o    <= data_tx_i[w_first_idx];
                            r_drv_cnt <= (CNT_W+1)'(1);
                        end else begin
                            r_drv_cnt <= '0;
                        end
                    end
                end
                ST_XFER: begin
                    if (ss_i) begin
                        r_state <= ST_IDLE;
                        abort_o <= 1'b1;
                    end else begin
                        if (w_drive && w_drv_ok) begin
                            mosi_o    <= r_tx[w_tx_idx];
                            r_drv_cnt <= r_drv_cnt + (CNT_W+1)'(1);
                        end
                        if (w_sample) begin
                            r_rx <= w_rx_next;
                            if (r_cnt == r_len) begin
                                data_rx_o <= w_rx_next;
                                done_o    <= 1'b1;
                                r_state   <= ST_IDLE;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine_p.sv
// Directed bench for spi_shift_engine_p: an 8-bit instance with miso looped back
// to mosi, and a 16-bit instance with miso held high.
module tb_spi_shift_engine_p;

    logic        PCLK = 1'b0;
    logic        rst_n, ss, start, sel, lsbfe, cpha, lead, trail;
    logic [7:0]  tx8;
    logic [2:0]  len8;
    logic [15:0] tx16;
    logic [3:0]  len16;

    logic        mosi8, busy8, done8, abort8;
    logic [7:0]  rx8;
    logic        mosi16, busy16, done16, abort16;
    logic [15:0] rx16;

    logic        mosi_m, busy_m, done_m, abort_m;
    logic [31:0] rx_m;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    always #5 PCLK = ~PCLK;

    spi_shift_engine_p #(.DATA_W(8)) dut8 (
        .PCLK(PCLK), .PRESET_n(rst_n), .ss_i(ss), .start_i(start & ~sel),
        .data_tx_i(tx8), .len_i(len8), .lsbfe_i(lsbfe), .cpha_i(cpha),
        .lead_edge_i(lead), .trail_edge_i(trail), .miso_i(mosi8),
        .mosi_o(mosi8), .data_rx_o(rx8), .busy_o(busy8), .done_o(done8), .abort_o(abort8)
    );

    spi_shift_engine_p #(.DATA_W(16)) dut16 (
        .PCLK(PCLK), .PRESET_n(rst_n), .ss_i(ss), .start_i(start & sel),
        .data_tx_i(tx16), .len_i(len16), .lsbfe_i(lsbfe), .cpha_i(cpha),
        .lead_edge_i(lead), .trail_edge_i(trail), .miso_i(1'b1),
        .mosi_o(mosi16), .data_rx_o(rx16), .busy_o(busy16), .done_o(done16), .abort_o(abort16)
    );

    assign mosi_m  = sel ? mosi16  : mosi8;
    assign busy_m  = sel ? busy16  : busy8;
    assign done_m  = sel ? done16  : done8;
    assign abort_m = sel ? abort16 : abort8;
    assign rx_m    = sel ? {16'h0, rx16} : {24'h0, rx8};

    always @(posedge PCLK) begin
        if (done8 || done16)   done_cnt  <= done_cnt + 1;
        if (abort8 || abort16) abort_cnt <= abort_cnt + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic pulse(input logic l, input logic t);
        lead  = l;
        trail = t;
        step();
        lead  = 1'b0;
        trail = 1'b0;
    endtask

    // seq[k] is the k-th bit expected on mosi; stress adds an ignored start and spare strobes.
    task automatic frame(input string tag, input int len, input logic [31:0] seq,
                         input logic [31:0] exp_rx, input logic idle_mosi, input bit stress);
        int d0;
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        check_value({tag, " busy@start"}, 32'(busy_m), 32'd1);
        if (cpha) begin
            step();
            check_value({tag, " mosi hold"}, 32'(mosi_m), 32'(idle_mosi));
        end
        for (int k = 0; k <= len; k++) begin
            if (stress && k == 2) begin
                tx8 = 8'hFF; len8 = 3'd2; lsbfe = ~lsbfe; cpha = ~cpha; start = 1'b1;
                step();
                start = 1'b0; lsbfe = ~lsbfe; cpha = ~cpha;
            end
            if (!cpha) begin
                if (stress && k == len) pulse(1'b0, 1'b1);
                check_value($sformatf("%s mosi[%0d]", tag, k), 32'(mosi_m), 32'(seq[k]));
                pulse(1'b1, 1'b0);
            end else begin
                pulse(1'b1, 1'b0);
                check_value($sformatf("%s mosi[%0d]", tag, k), 32'(mosi_m), 32'(seq[k]));
                pulse(1'b0, 1'b1);
            end
            if (k == len) begin
                check_value({tag, " done"}, 32'(done_m), 32'd1);
                check_value({tag, " busy@done"}, 32'(busy_m), 32'd0);
                check_value({tag, " rx"}, rx_m, exp_rx);
            end else begin
                check_value($sformatf("%s busy[%0d]", tag, k), 32'(busy_m), 32'd1);
                if (!cpha) pulse(1'b0, 1'b1);
            end
        end
        if (stress) begin
            pulse(1'b0, 1'b1);
            pulse(1'b1, 1'b1);
            check_value({tag, " mosi idle"}, 32'(mosi_m), 32'(seq[len]));
        end
        step();
        check_value({tag, " done count"}, 32'(done_cnt - d0), 32'd1);
        check_value({tag, " done low"}, 32'(done_m), 32'd0);
    endtask

    initial begin
        int d0, a0;
        rst_n = 1'b0; ss = 1'b0; start = 1'b0; sel = 1'b0; lsbfe = 1'b0; cpha = 1'b0;
        lead = 1'b0; trail = 1'b0; tx8 = '0; len8 = '0; tx16 = '0; len16 = '0;
        step();
        step();
        check_value("rst mosi",  32'(mosi8),  32'd0);
        check_value("rst rx",    32'(rx8),    32'd0);
        check_value("rst busy",  32'(busy8),  32'd0);
        check_value("rst done",  32'(done8),  32'd0);
        check_value("rst abort", 32'(abort8), 32'd0);
        rst_n = 1'b1;
        step();

        // MSB first, cpha=0, 0xA5 looped back
        tx8 = 8'hA5; len8 = 3'd7; lsbfe = 1'b0; cpha = 1'b0;
        frame("msb_cpha0", 7, 32'hA5, 32'hA5, 1'b0, 1'b0);

        // abort after three samples of 0x5A; mosi is left on bit 3 (=1)
        d0 = done_cnt;
        tx8 = 8'h5A;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1'b0);
            pulse(1'b0, 1'b1);
        end
        ss = 1'b1;
        step();
        check_value("abort pulse", 32'(abort8), 32'd1);
        check_value("abort busy",  32'(busy8),  32'd0);
        check_value("abort rx",    32'(rx8),    32'hA5);
        ss = 1'b0;
        step();
        check_value("abort low",   32'(abort8), 32'd0);
        check_value("abort rx2",   32'(rx8),    32'hA5);
        check_value("abort nodone", 32'(done_cnt - d0), 32'd0);

        // LSB first, cpha=1, 0x3C; mosi holds 1 until the first lead edge
        tx8 = 8'h3C; lsbfe = 1'b1; cpha = 1'b1;
        frame("lsb_cpha1", 7, 32'h3C, 32'h3C, 1'b1, 1'b0);

        // 16-bit instance, 5-bit frame of 0x0015 (1,0,1,0,1), miso high
        sel = 1'b1; tx16 = 16'h0015; len16 = 4'd4; lsbfe = 1'b0; cpha = 1'b0;
        frame("w16_len4", 4, 32'h15, 32'h1F, 1'b0, 1'b0);
        sel = 1'b0;

        // start during XFER and spare strobes are ignored
        tx8 = 8'hC3; len8 = 3'd7; lsbfe = 1'b0; cpha = 1'b0;
        frame("ignore", 7, 32'hC3, 32'hC3, 1'b0, 1'b1);

        // asynchronous reset mid-frame
        tx8 = 8'h5A; len8 = 3'd7;
        start = 1'b1; step(); start = 1'b0;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_value("arst mosi", 32'(mosi8), 32'd0);
        check_value("arst rx",   32'(rx8),   32'd0);
        check_value("arst busy", 32'(busy8), 32'd0);
        step();
        rst_n = 1'b1;
        d0 = done_cnt; a0 = abort_cnt;
        step(); step(); step();
        check_value("arst nodone",  32'(done_cnt - d0),  32'd0);
        check_value("arst noabort", 32'(abort_cnt - a0), 32'd0);
        tx8 = 8'hA5;
        frame("after_rst", 7, 32'hA5, 32'hA5, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/spi_shift_engine_p.md
SPI_SHIFT_ENGINE_P -- requirements
Module: spi_shift_engine_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8, maximum frame width in bits (legal 2..32).
REQ-002 SHALL have derived parameter CNT_W, default $clog2(DATA_W), bit-index width.
REQ-003 SHALL have port PCLK  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port PRESET_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ss_i  in  1  slave select, active-low; high aborts any transfer.
REQ-006 SHALL have port start_i  in  1  one-cycle request to load data_tx_i and begin a frame.
REQ-007 SHALL have port data_tx_i  in  DATA_W  transmit word.
REQ-008 SHALL have port len_i  in  CNT_W  frame length minus one (0 -> 1 bit, DATA_W-1 -> full).
REQ-009 SHALL have port lsbfe_i  in  1  1 = LSB first, 0 = MSB first.
REQ-010 SHALL have port cpha_i  in  1  clock phase select.
REQ-011 SHALL have port lead_edge_i  in  1  one-PCLK strobe marking an SCLK leading edge.
REQ-012 SHALL have port trail_edge_i  in  1  one-PCLK strobe marking an SCLK trailing edge.
REQ-013 SHALL have port miso_i  in  1  serial receive data.
REQ-014 SHALL have port mosi_o  out  1  serial transmit data.
REQ-015 SHALL have port data_rx_o  out  DATA_W  last completed received word.
REQ-016 SHALL have port busy_o  out  1  high while in XFER.
REQ-017 SHALL have port done_o  out  1  one-cycle pulse on frame completion.
REQ-018 SHALL have port abort_o  out  1  one-cycle pulse when ss_i terminates a frame early.

Function
REQ-019 SHALL implement states IDLE and XFER; busy_o = (state == XFER).
REQ-020 IDLE + start_i + !ss_i: load tx shadow from data_tx_i, latch len_i/lsbfe_i/cpha_i, clear bit counter and rx shadow, go XFER; start_i in XFER or with ss_i high ignored.
REQ-021 Latched len/lsbfe/cpha SHALL govern the whole frame; input changes mid-frame have no effect.
REQ-022 Bit k (k = 0..len) SHALL map to word index k when LSB-first, len-k when MSB-first, for both transmit and receive.
REQ-023 cpha=0: mosi_o SHALL present bit 0 the cycle after start; sample on lead_edge_i; next bit driven on trail_edge_i.
REQ-024 cpha=1: mosi_o SHALL hold until first lead_edge_i, which drives bit 0; later lead_edge_i drive next bit; sample on trail_edge_i.
REQ-025 Each sample SHALL write miso_i into the rx shadow at the REQ-022 index and increment the bit counter.
REQ-026 Shift strobes after bit len is driven SHALL be ignored (no extra bit, no counter wrap).
REQ-027 lead_edge_i and trail_edge_i in the same cycle SHALL both be processed (sample and drive independent).
REQ-028 On the sample of bit len, next cycle: data_rx_o <= rx shadow (bits above len zero), done_o = 1, state -> IDLE.
REQ-029 ss_i high in XFER: state -> IDLE next cycle, abort_o = 1, data_rx_o unchanged, no done_o.
REQ-030 ss_i rising on the same cycle as the final sample: abort takes priority; no done_o.
REQ-031 mosi_o SHALL hold its last driven value in IDLE.
REQ-032 Strobes in IDLE SHALL have no effect.

Reset
REQ-033 PRESET_n low SHALL asynchronously force IDLE, mosi_o=0, data_rx_o=0, busy_o=0, done_o=0, abort_o=0, counter and shadows 0.
REQ-034 Reset mid-frame SHALL discard the frame with no done_o/abort_o pulse after release.

Verification
REQ-035 DATA_W=8, len=7, lsbfe=0, cpha=0, tx=0xA5, miso looped to mosi, 8 lead/trail pairs -> mosi sequence 1,0,1,0,0,1,0,1; done_o pulse; data_rx_o=0xA5.
REQ-036 Same with lsbfe=1, cpha=1, tx=0x3C -> mosi 0,0,1,1,1,1,0,0; data_rx_o=0x3C; mosi unchanged before first lead_edge_i.
REQ-037 DATA_W=16, len=4, lsbfe=0, miso fixed 1 -> 5 bits sent, data_rx_o=0x001F, busy_o high exactly until done_o cycle.
REQ-038 ss_i high after 3 samples -> abort_o pulse, no done_o, data_rx_o holds prior 0xA5.
REQ-039 start_i in XFER plus extra trail_edge_i after last bit -> no reload, no extra bit, single done_o.
REQ-040 PRESET_n low mid-frame -> all outputs 0 immediately; new frame after release completes normally.
